// File: rtl/ex_unit.sv
// -----------------------------------------------------------------------------
// ex_unit - execute stage of the 5-stage MIPS pipeline.
//
// Evaluates logic, shift and HI/LO move instructions in one cycle and registers
// the ex/mem bundle (wd_o, wreg_o, wdata_o). MULT/MULTU run on an iterative
// 32-step shift-add engine that owns the HI/LO pair and holds the upstream
// pipeline through stall_o while it works.
//
// Handshake: stall_o is the only flow control. While stall_o=1 the upstream
// stage must hold aluop_i/alusel_i/reg1_i/reg2_i/wd_i/wreg_i stable. When
// stall_o=0 the instruction at the inputs is consumed at the next rising edge.
//
// Ports:
//   clk       pipeline clock
//   rst       asynchronous reset, active-low
//   aluop_i   operation code from decode
//   alusel_i  result class from decode
//   reg1_i    operand 1 (register or immediate)
//   reg2_i    operand 2 (register or immediate)
//   wd_i      destination GPR address
//   wreg_i    GPR write enable
//   stall_o   combinational, 1 = upstream must hold its inputs this cycle
//   wd_o      registered destination address
//   wreg_o    registered GPR write enable
//   wdata_o   registered result
//   hi_o      HI register
//   lo_o      LO register
// -----------------------------------------------------------------------------
module ex_unit #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic        stall_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h12;

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE  = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        sign_q, sign_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;

  logic        is_mul;
  logic        is_signed_mul;
  logic [31:0] mag1, mag2;
  logic [32:0] addend, upper_sum;
  logic [63:0] product, product_fixed;
  logic [31:0] alu_res;
  logic        bubble;

  assign is_mul        = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
  assign is_signed_mul = (aluop_i == OP_MULT);

  // Magnitudes are taken only for signed MULT; -32'h8000_0000 wraps to its own
  // bit pattern, which is the correct unsigned magnitude.
  assign mag1 = (is_signed_mul && reg1_i[31]) ? -reg1_i : reg1_i;
  assign mag2 = (is_signed_mul && reg2_i[31]) ? -reg2_i : reg2_i;

  // One shift-add step: bit 64 of the accumulator catches the carry out of the
  // upper-half add before the whole 65-bit value is shifted right.
  assign addend    = mplier_q[0] ? {1'b0, mcand_q} : 33'd0;
  assign upper_sum = acc_q[64:32] + addend;

  assign product       = acc_q[63:0];
  assign product_fixed = sign_q ? (~product + 64'd1) : product;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (is_mul) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == 6'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs. Stall is gated by reset so every output reads 0 while reset
  // is asserted, even with a multiply sitting at the inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_o = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = rst & is_mul;
        bubble  = is_mul;
      end
      S_BUSY: begin
        stall_o = rst;
        bubble  = 1'b1;
      end
      S_DONE: begin
        bubble  = 1'b1;
      end
      default: begin
        bubble  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply engine and HI/LO next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          mcand_d  = mag1;
          mplier_d = mag2;
          sign_d   = is_signed_mul & (reg1_i[31] ^ reg2_i[31]);
          cnt_d    = 6'(MUL_CYCLES);
          acc_d    = 65'd0;
        end
      end
      S_BUSY: begin
        acc_d    = {upper_sum, acc_q[31:0]} >> 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 6'd1;
      end
      S_DONE: begin
        hi_d = product_fixed[63:32];
        lo_d = product_fixed[31:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 6'd0;
      acc_q    <= 65'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      sign_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU. Anything not recognised produces 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res = 32'd0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_OR:   alu_res = reg1_i | reg2_i;
          OP_AND:  alu_res = reg1_i & reg2_i;
          OP_XOR:  alu_res = reg1_i ^ reg2_i;
          OP_NOR:  alu_res = ~(reg1_i | reg2_i);
          default: alu_res = 32'd0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  alu_res = reg2_i << reg1_i[4:0];
          OP_SRL:  alu_res = reg2_i >> reg1_i[4:0];
          OP_SRA:  alu_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default: alu_res = 32'd0;
        endcase
      end
      SEL_MOVE: begin
        case (aluop_i)
          OP_MFHI: alu_res = hi_q;
          OP_MFLO: alu_res = lo_q;
          default: alu_res = 32'd0;
        endcase
      end
      SEL_NOP: alu_res = (aluop_i == OP_NOP) ? 32'd0 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ex/mem register. Multiplies never write a GPR, so every cycle they occupy
  // the stage is a bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    wd_d    = wd_i;
    wreg_d  = wreg_i;
    wdata_d = alu_res;
    if (bubble) begin
      wd_d    = 5'd0;
      wreg_d  = 1'b0;
      wdata_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule
